// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, stall vectors and FSM state encoding for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_PEND = 2'd1,
    RED_PEND = 2'd2
  } pipe_ctrl_state_e;

  // Deepest requesting stage wins; result is always a thermometer code.
  function automatic logic [5:0] stall_vec(input logic mem, input logic ex,
                                           input logic id, input logic fe);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else if (fe) return STALL_IF;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle; perf counter signals exist only with PIPE_CTRL_PERF_EN
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        exception_i;
  logic [63:0] trap_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        flush_front_o;
  logic        pc_load_o;
  logic [63:0] new_pc_o;
  logic        stall_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] perf_cycles_o;
  logic [63:0] perf_stall_o;
  logic [63:0] perf_flush_o;
`endif

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output redirect_i, redirect_pc_i, exception_i, trap_pc_i,
`ifdef PIPE_CTRL_PERF_EN
    input  perf_cycles_o, perf_stall_o, perf_flush_o,
`endif
    input  stall_o, flush_o, flush_front_o, pc_load_o, new_pc_o, stall_timeout_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  redirect_i, redirect_pc_i, exception_i, trap_pc_i,
`ifdef PIPE_CTRL_PERF_EN
    output perf_cycles_o, perf_stall_o, perf_flush_o,
`endif
    output stall_o, flush_o, flush_front_o, pc_load_o, new_pc_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// rtl/pipe_ctrl_perf.sv - free-running cycle, stall-cycle and flush-pulse counters (64-bit, wrapping)
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush_any,
  output logic [63:0] cycles,
  output logic [63:0] stalls,
  output logic [63:0] flushes
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      stalls  <= '0;
      flushes <= '0;
    end else begin
      cycles <= cycles + 64'd1;
      if (stall_pc)  stalls  <= stalls + 64'd1;
      if (flush_any) flushes <= flushes + 64'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller with stall watchdog
// Optional perf counters under PIPE_CTRL_PERF_EN.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'(RUN);
  localparam logic [1:0] ST_EXC_PEND = 2'(EXC_PEND);
  localparam logic [1:0] ST_RED_PEND = 2'(RED_PEND);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(STALL_TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic [63:0]      pend_pc, pend_pc_nxt;
  logic [5:0]       req_stall, stall;
  logic             flush, flush_front, pc_load;
  logic [63:0]      new_pc;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_sticky, wd_hit;

  always_comb begin
    req_stall   = stall_vec(bus.stallreq_mem_i, bus.stallreq_ex_i,
                            bus.stallreq_id_i, bus.stallreq_if_i);
    stall       = req_stall;
    flush       = 1'b0;
    flush_front = 1'b0;
    pc_load     = 1'b0;
    new_pc      = '0;
    state_nxt   = state;
    pend_pc_nxt = pend_pc;

    case (state)
      ST_EXC_PEND: begin
        if (!bus.stallreq_mem_i) begin
          flush     = 1'b1;
          pc_load   = 1'b1;
          new_pc    = pend_pc;
          stall     = STALL_NONE;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        // An exception always overrides a live or pending redirect.
        if (bus.exception_i) begin
          if (!bus.stallreq_mem_i) begin
            flush     = 1'b1;
            pc_load   = 1'b1;
            new_pc    = bus.trap_pc_i;
            stall     = STALL_NONE;
            state_nxt = ST_RUN;
          end else begin
            pend_pc_nxt = bus.trap_pc_i;
            state_nxt   = ST_EXC_PEND;
          end
        end else if (state == ST_RED_PEND) begin
          if (!req_stall[STG_EX]) begin
            flush_front = 1'b1;
            pc_load     = 1'b1;
            new_pc      = pend_pc;
            stall       = STALL_NONE;
            state_nxt   = ST_RUN;
          end
        end else if (bus.redirect_i) begin
          // Front-end stall requests belong to the wrong path and are dropped.
          if (!req_stall[STG_EX]) begin
            flush_front = 1'b1;
            pc_load     = 1'b1;
            new_pc      = bus.redirect_pc_i;
            stall       = STALL_NONE;
          end else begin
            pend_pc_nxt = bus.redirect_pc_i;
            state_nxt   = ST_RED_PEND;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  assign wd_hit = stall[STG_PC] && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      wd_sticky <= 1'b0;
    end else begin
      if (!stall[STG_PC])          wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) wd_sticky <= 1'b1;
    end
  end

  // Outputs are forced low while reset is held so the pipeline sees a clean idle.
  assign bus.stall_o         = rst ? STALL_NONE : stall;
  assign bus.flush_o         = ~rst & flush;
  assign bus.flush_front_o   = ~rst & flush_front;
  assign bus.pc_load_o       = ~rst & pc_load;
  assign bus.new_pc_o        = rst ? 64'd0 : new_pc;
  assign bus.stall_timeout_o = ~rst & (wd_sticky | wd_hit);

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_pc  (stall[STG_PC]),
    .flush_any (flush | flush_front),
    .cycles    (bus.perf_cycles_o),
    .stalls    (bus.perf_stall_o),
    .flushes   (bus.perf_flush_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - vector table, watchdog/reset sequence and randomized model check for pipe_ctrl
module tb_pipe_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_ctrl_if bus();

  pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic mem, ex, id, fe, red;
    logic [63:0] rpc;
    logic exc;
    logic [63:0] tpc;
    logic [5:0]  e_stall;
    logic e_flush, e_ff, e_load;
    logic [63:0] e_npc;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending events and the length of the current PC-stall run.
  bit          m_trap_pend, m_red_pend, m_to;
  logic [63:0] m_trap_pc, m_red_pc;
  int          m_run;
  logic [5:0]  x_stall;
  logic        x_flush, x_ff, x_load, x_to;
  logic [63:0] x_npc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mem, ex, id, fe, red, input logic [63:0] rpc,
                              input logic exc, input logic [63:0] tpc, input logic [5:0] st,
                              input logic fl, ff, ld, input logic [63:0] npc);
    vec_t v;
    v.mem = mem; v.ex = ex; v.id = id; v.fe = fe; v.red = red; v.rpc = rpc;
    v.exc = exc; v.tpc = tpc; v.e_stall = st; v.e_flush = fl; v.e_ff = ff;
    v.e_load = ld; v.e_npc = npc;
    return v;
  endfunction

  task automatic drive(input logic mem, ex, id, fe, red, input logic [63:0] rpc,
                       input logic exc, input logic [63:0] tpc);
    bus.stallreq_mem_i = mem; bus.stallreq_ex_i = ex;
    bus.stallreq_id_i = id;   bus.stallreq_if_i = fe;
    bus.redirect_i = red;     bus.redirect_pc_i = rpc;
    bus.exception_i = exc;    bus.trap_pc_i = tpc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {58'd0, bus.stall_o}, 64'd0);
    check({tag, "_flush"}, {63'd0, bus.flush_o}, 64'd0);
    check({tag, "_flush_front"}, {63'd0, bus.flush_front_o}, 64'd0);
    check({tag, "_pc_load"}, {63'd0, bus.pc_load_o}, 64'd0);
    check({tag, "_new_pc"}, bus.new_pc_o, 64'd0);
    check({tag, "_timeout"}, {63'd0, bus.stall_timeout_o}, 64'd0);
  endtask

  task automatic model_reset();
    m_trap_pend = 0; m_red_pend = 0; m_to = 0; m_run = 0;
    m_trap_pc = '0;  m_red_pc = '0;
  endtask

  // Called at rst=1 from a cycle boundary; returns at posedge+1 with rst released.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    rst = 1'b1;
    #1 check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_eval();
    logic mem, ex, id, fe;
    mem = bus.stallreq_mem_i; ex = bus.stallreq_ex_i;
    id = bus.stallreq_id_i;   fe = bus.stallreq_if_i;
    x_stall = mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : fe ? 6'b000011 : 6'b000000;
    x_flush = 0; x_ff = 0; x_load = 0; x_npc = '0;
    if (m_trap_pend) begin
      if (!mem) begin
        x_flush = 1; x_load = 1; x_npc = m_trap_pc; x_stall = '0; m_trap_pend = 0;
      end
    end else if (bus.exception_i) begin
      m_red_pend = 0;
      if (!mem) begin
        x_flush = 1; x_load = 1; x_npc = bus.trap_pc_i; x_stall = '0;
      end else begin
        m_trap_pend = 1; m_trap_pc = bus.trap_pc_i;
      end
    end else if (m_red_pend) begin
      if (!(mem || ex)) begin
        x_ff = 1; x_load = 1; x_npc = m_red_pc; x_stall = '0; m_red_pend = 0;
      end
    end else if (bus.redirect_i) begin
      if (!(mem || ex)) begin
        x_ff = 1; x_load = 1; x_npc = bus.redirect_pc_i; x_stall = '0;
      end else begin
        m_red_pend = 1; m_red_pc = bus.redirect_pc_i;
      end
    end
    x_to = m_to || (x_stall[0] && m_run >= TO - 1);
    m_to = x_to;
    m_run = x_stall[0] ? m_run + 1 : 0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    do_reset();

    // mem, ex, id, if, red, rpc, exc, tpc -> stall, flush, flush_front, pc_load, new_pc
    vecs.push_back(mk(1,0,0,1, 0,64'd0, 0,64'd0, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,1, 0,64'd0, 0,64'd0, 6'b000011, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 1,64'h8000_0100, 6'b000000, 1,0,1, 64'h8000_0100));
    vecs.push_back(mk(1,0,0,0, 0,64'd0, 1,64'h8000_0200, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(1,0,0,0, 0,64'd0, 0,64'd0, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(1,0,0,0, 0,64'd0, 0,64'd0, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 1,0,1, 64'h8000_0200));
    vecs.push_back(mk(0,1,0,0, 1,64'h8000_0040, 0,64'd0, 6'b001111, 0,0,0, 64'd0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,0, 0,64'd0, 0,64'd0, 6'b001111, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 0,1,1, 64'h8000_0040));
    vecs.push_back(mk(0,0,1,1, 1,64'h8000_0080, 0,64'd0, 6'b000000, 0,1,1, 64'h8000_0080));
    vecs.push_back(mk(0,1,0,0, 1,64'h8000_00c0, 0,64'd0, 6'b001111, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 1,64'h8000_0300, 6'b000000, 1,0,1, 64'h8000_0300));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 0,0,0, 64'd0));
    vecs.push_back(mk(1,0,0,0, 1,64'h8000_0500, 0,64'd0, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(1,0,0,0, 0,64'd0, 1,64'h8000_0380, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(1,0,0,0, 1,64'h8000_0600, 1,64'h8000_0400, 6'b011111, 0,0,0, 64'd0));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 1,0,1, 64'h8000_0380));
    vecs.push_back(mk(0,0,0,0, 0,64'd0, 0,64'd0, 6'b000000, 0,0,0, 64'd0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.mem, v.ex, v.id, v.fe, v.red, v.rpc, v.exc, v.tpc);
      #2;
      check($sformatf("vec%0d_stall", i), {58'd0, bus.stall_o}, {58'd0, v.e_stall});
      check($sformatf("vec%0d_flush", i), {63'd0, bus.flush_o}, {63'd0, v.e_flush});
      check($sformatf("vec%0d_flush_front", i), {63'd0, bus.flush_front_o}, {63'd0, v.e_ff});
      check($sformatf("vec%0d_pc_load", i), {63'd0, bus.pc_load_o}, {63'd0, v.e_load});
      check($sformatf("vec%0d_new_pc", i), bus.new_pc_o, v.e_npc);
      @(posedge clk); #1;
    end

    // Watchdog: fires on the TO-th consecutive stalled cycle and stays set.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1, 0, 64'd0, 0, 64'd0);
      #2;
      check($sformatf("wd_stall%0d", i), {58'd0, bus.stall_o}, 64'b000011);
      check($sformatf("wd_timeout%0d", i), {63'd0, bus.stall_timeout_o}, (i >= TO) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
      #2;
      check("wd_sticky", {63'd0, bus.stall_timeout_o}, 64'd1);
      @(posedge clk); #1;
    end
    drive(1, 0, 0, 1, 0, 64'd0, 1, 64'h8000_0700);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
    rst = 1'b0;
    #2;
    check("post_rst_timeout", {63'd0, bus.stall_timeout_o}, 64'd0);
    check("post_rst_flush", {63'd0, bus.flush_o}, 64'd0);
    @(posedge clk); #1;
    model_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 249) begin
        do_reset();
      end else begin
        drive($urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(4, 0) == 0,
              $urandom_range(9, 0) < 3, $urandom_range(19, 0) < 3, {$urandom, $urandom},
              $urandom_range(24, 0) < 2, {$urandom, $urandom});
        #2;
        model_eval();
        check("rnd_stall", {58'd0, bus.stall_o}, {58'd0, x_stall});
        check("rnd_flush", {63'd0, bus.flush_o}, {63'd0, x_flush});
        check("rnd_flush_front", {63'd0, bus.flush_front_o}, {63'd0, x_ff});
        check("rnd_pc_load", {63'd0, bus.pc_load_o}, {63'd0, x_load});
        check("rnd_new_pc", bus.new_pc_o, x_npc);
        check("rnd_timeout", {63'd0, bus.stall_timeout_o}, {63'd0, x_to});
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
